button_pulse: RTL and testbench

BUTTON_PULSE -- requirements
Module: button_pulse

---
 rtl/button_pulse.sv | 106 ++++++++++
 tb/tb_button_pulse.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/button_pulse.sv
// Button debouncer: 2-flop synchronizer feeding a 4-state FSM that emits
// registered press/release/long-press strobes and a wrapping press counter.
module button_pulse #(
    parameter int cycle      = 250,
    parameter int long_cycle = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_in,
    output logic       pressed,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_press,
    output logic [7:0] press_count
);

    localparam int DW = $clog2(cycle + 1);
    localparam int HW = $clog2(long_cycle + 1);

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] HELD         = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    // Compare against "last count" so the transition lands on the edge the count reaches cycle.
    localparam logic [DW-1:0] DB_LAST   = DW'(cycle - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(long_cycle);
    localparam logic [HW-1:0] HOLD_LAST = HW'(long_cycle - 1);

    logic          s1, s2;
    logic [1:0]    state;
    logic [DW-1:0] db_cnt;
    logic [HW-1:0] hold_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1            <= 1'b0;
            s2            <= 1'b0;
            state         <= IDLE;
            db_cnt        <= '0;
            hold_cnt      <= '0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            s1            <= btn_in;
            s2            <= s1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            case (state)
                IDLE: begin
                    if (s2) begin
                        state  <= PRESS_WAIT;
                        db_cnt <= DW'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (!s2) begin
                        state  <= IDLE;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state       <= HELD;
                        db_cnt      <= '0;
                        hold_cnt    <= '0;
                        pressed     <= 1'b1;
                        press_pulse <= 1'b1;
                        press_count <= press_count + 8'd1;
                    end else begin
                        db_cnt <= db_cnt + DW'(1);
                    end
                end
                HELD: begin
                    if (s2) begin
                        // Saturate so long_press fires once per press.
                        if (hold_cnt != HOLD_MAX) begin
                            hold_cnt <= hold_cnt + HW'(1);
                            if (hold_cnt == HOLD_LAST)
                                long_press <= 1'b1;
                        end
                    end else begin
                        state  <= RELEASE_WAIT;
                        db_cnt <= DW'(1);
                    end
                end
                RELEASE_WAIT: begin
                    if (s2) begin
                        state  <= HELD;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state         <= IDLE;
                        db_cnt        <= '0;
                        pressed       <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + DW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_button_pulse.sv
// Bench for button_pulse: directed scenarios plus random bouncing input,
// checked every cycle against a run-length debounce model.
module tb_button_pulse;

    localparam int CYC = 4;
    localparam int LC  = 8;

    logic       clk = 1'b0;
    logic       reset, btn_in;
    logic       pressed, press_pulse, release_pulse, long_press;
    logic [7:0] press_count;

    button_pulse #(.cycle(CYC), .long_cycle(LC)) dut (
        .clk(clk), .reset(reset), .btn_in(btn_in),
        .pressed(pressed), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .long_press(long_press), .press_count(press_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Model: a level change is accepted after CYC consecutive synchronized
    // samples disagreeing with the current accepted level.
    int m_s1, m_s2, m_lvl, m_run, m_hold, m_cnt;
    int e_pp, e_rp, e_lp;

    task automatic model_edge(input bit rst, input bit btn);
        int smp;
        e_pp = 0; e_rp = 0; e_lp = 0;
        if (!rst) begin
            m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0; m_hold = 0; m_cnt = 0;
        end else begin
            smp = m_s2;
            if (smp != m_lvl) begin
                m_run++;
                if (m_run == CYC) begin
                    m_lvl = smp;
                    m_run = 0;
                    if (smp == 1) begin
                        e_pp = 1; m_cnt = (m_cnt + 1) % 256; m_hold = 0;
                    end else begin
                        e_rp = 1;
                    end
                end
            end else begin
                // A held sample counts only if no release run was in progress.
                if (smp == 1 && m_run == 0 && m_hold < LC) begin
                    m_hold++;
                    if (m_hold == LC) e_lp = 1;
                end
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = btn;
        end
    endtask

    int ec, pp_n, rp_n, lp_n, pp_at, lp_at;

    task automatic clr_stats();
        ec = 0; pp_n = 0; rp_n = 0; lp_n = 0; pp_at = -1; lp_at = -1;
    endtask

    task automatic step(input bit rst, input bit btn);
        reset  = rst;
        btn_in = btn;
        @(posedge clk);
        model_edge(rst, btn);
        ec++;
        #1;
        chk("pressed", int'(pressed), m_lvl);
        chk("press_pulse", int'(press_pulse), e_pp);
        chk("release_pulse", int'(release_pulse), e_rp);
        chk("long_press", int'(long_press), e_lp);
        chk("press_count", int'(press_count), m_cnt);
        if (press_pulse) begin pp_n++; if (pp_at < 0) pp_at = ec; end
        if (release_pulse) rp_n++;
        if (long_press) begin lp_n++; if (lp_at < 0) lp_at = ec; end
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        clr_stats();
    endtask

    task automatic hold(input bit btn, input int n);
        for (int i = 0; i < n; i++) step(1'b1, btn);
    endtask

    initial begin
        reset = 1'b0; btn_in = 1'b0;
        m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0; m_hold = 0; m_cnt = 0;
        clr_stats();

        // Reset state
        do_reset();
        chk("rst_pressed", int'(pressed), 0);
        chk("rst_count", int'(press_count), 0);

        // Clean press: pulse after edge CYC+2
        hold(1'b1, 20);
        chk("clean_pp_edge", pp_at, CYC + 2);
        chk("clean_pp_n", pp_n, 1);
        chk("clean_count", int'(press_count), 1);
        chk("clean_pressed", int'(pressed), 1);

        // Bounce shorter than the debounce window
        do_reset();
        for (int k = 0; k < 2; k++) begin hold(1'b1, 2); hold(1'b0, 2); end
        hold(1'b0, 10);
        chk("bounce_pp_n", pp_n, 0);
        chk("bounce_pressed", int'(pressed), 0);
        chk("bounce_count", int'(press_count), 0);

        // Long press then release
        do_reset();
        hold(1'b1, 30);
        chk("long_lp_n", lp_n, 1);
        chk("long_lp_delay", lp_at - pp_at, LC);
        hold(1'b0, 10);
        chk("long_rp_n", rp_n, 1);
        chk("long_pressed", int'(pressed), 0);

        // Release glitch while held
        do_reset();
        hold(1'b1, 10);
        hold(1'b0, 2);
        hold(1'b1, 10);
        chk("glitch_rp_n", rp_n, 0);
        chk("glitch_pressed", int'(pressed), 1);
        chk("glitch_count", int'(press_count), 1);

        // Reset mid-hold with button still down
        do_reset();
        hold(1'b1, 10);
        step(1'b0, 1'b1);
        chk("midrst_pressed", int'(pressed), 0);
        chk("midrst_count", int'(press_count), 0);
        clr_stats();
        hold(1'b1, 10);
        chk("midrst_pp_edge", pp_at, CYC + 2);
        chk("midrst_rp_n", rp_n, 0);
        chk("midrst_count2", int'(press_count), 1);

        // 256 presses wrap the counter
        do_reset();
        for (int k = 0; k < 256; k++) begin hold(1'b1, 8); hold(1'b0, 8); end
        chk("wrap_count", int'(press_count), 0);
        chk("wrap_rp_n", rp_n, 256);
        chk("wrap_pp_n", pp_n, 256);

        // Random bouncing with occasional resets
        do_reset();
        for (int k = 0; k < 400; k++) begin
            bit lvl;
            int len;
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 14);
            if ($urandom_range(0, 49) == 0) step(1'b0, lvl);
            hold(lvl, len);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
